btn_debouncer: RTL
==================

Name: btn_debouncer

Overview:
- Conditioning stage directly upstream of the VGA top level. Takes the five raw Nexys4 push buttons (BtnU, BtnD, BtnL, BtnR, BtnC) and produces synchronised, debounced levels for each one.
- Also produces single-cycle press and release pulses per button.
- These outputs replace the raw buttons currently wired straight into block_controller and the reset path, so object movement and game actions see clean edges.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (10 ms at 100 MHz). Legal range 2..2^24.
- REPEAT_DELAY, 50000000, cycles held before the first auto-repeat pulse. Used only with BTN_REPEAT_EN.
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat pulses. Used only with BTN_REPEAT_EN.

Ports:
- clk, input, 1, system clock (100 MHz ClkPort).
- rst_n, input, 1, asynchronous active-low reset.
- btn_raw, input, NUM_BTN, raw asynchronous button inputs, active-high. Bit order {C,R,L,D,U} = [4:0].
- btn_level, output, NUM_BTN, debounced level per button.
- btn_press, output, NUM_BTN, one-cycle pulse when a press is accepted (plus repeats with BTN_REPEAT_EN).
- btn_release, output, NUM_BTN, one-cycle pulse when a release is accepted.

Behaviour:
- Channels are fully independent; no cross-channel interaction.
- Reset (rst_n low, asynchronous): synchroniser flops, counters, FSM, btn_level, btn_press and btn_release all go to 0. State is IDLE.
- Synchroniser: two flops per channel, giving sync = btn_raw delayed by 2 clk edges.
- Debounce counter:
  - Counts while sync differs from btn_level.
  - Clears to 0 on any cycle where sync equals btn_level (a bounce restarts the count).
  - Width is $clog2(DEBOUNCE_CYCLES).
- Per-channel FSM:
  - IDLE (level 0): sync=1 moves to PRESS_CNT, counter=1.
  - PRESS_CNT: sync=0 returns to IDLE, counter=0. When counter==DEBOUNCE_CYCLES-1 and sync=1, move to HELD, btn_level<=1, btn_press<=1 for that one cycle.
  - HELD (level 1): sync=0 moves to RELEASE_CNT, counter=1.
  - RELEASE_CNT: sync=1 returns to HELD. When counter==DEBOUNCE_CYCLES-1 and sync=0, move to IDLE, btn_level<=0, btn_release<=1 for that one cycle.
- Latency: a clean raw edge reaches btn_level and the pulse exactly DEBOUNCE_CYCLES+2 clk edges after the first edge that samples it.
- All outputs are registered; pulses are exactly one cycle wide.
- btn_press and btn_release are never high together on the same channel.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no output change.
- Button already held when rst_n deasserts: treated as a new press, so one btn_press fires after DEBOUNCE_CYCLES+2 cycles.
- Reset mid-count: the count is discarded and no pulse is emitted.
- Counter must not overflow or wrap; it saturates at DEBOUNCE_CYCLES-1, since transitions occur there.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- When defined:
  - In HELD, a repeat counter starts at 0 on the press edge.
  - When it reaches REPEAT_DELAY-1, btn_press pulses once and the counter reloads.
  - After that, btn_press pulses every REPEAT_PERIOD cycles while in HELD.
  - Leaving HELD (entering RELEASE_CNT) clears the repeat counter. A bounce back to HELD restarts the delay from 0.
  - The repeat counter is reset by rst_n.
- When undefined: no repeat counter is synthesised. btn_press fires exactly once per accepted press, and REPEAT_* parameters are ignored.

Decomposition:
- Package btn_pkg:
  - FSM state typedef: IDLE=2'b00, PRESS_CNT=2'b01, HELD=2'b10, RELEASE_CNT=2'b11.
  - Default constants DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF.
  - Button index constants BTN_U=0, BTN_D=1, BTN_L=2, BTN_R=3, BTN_C=4.
- Sub-module btn_debounce_ch: one channel (synchroniser, counter, FSM, optional repeat). btn_debouncer instantiates NUM_BTN copies with a generate loop.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6 for simulation):
- Reset: hold rst_n=0 with btn_raw=5'h1F, release -> all outputs 0 during reset; btn_level=5'h1F and btn_press=5'h1F for one cycle, 10 cycles after the first sampling edge.
- Clean press/release on BtnU: raise bit 0 for 40 cycles then drop -> btn_press[0] one cycle at edge 10, btn_level[0] high edges 10..49, btn_release[0] one cycle at edge 50.
- Bounce: toggle bit 2 with pulses of 3 high / 2 low for 30 cycles, then hold high -> no output during bouncing; one btn_press[2] 10 cycles after the final rise.
- Independence and simultaneous events: press bit 1 and release bit 3 on the same cycle -> btn_press[1] and btn_release[3] in the same cycle; other bits unchanged.
- Reset mid-count: raise bit 4, assert rst_n low at cycle 5 for 2 cycles, keep bit 4 high -> no pulse before reset; a single btn_press[4] 10 cycles after rst_n deasserts.
- BTN_REPEAT_EN: hold bit 0 for 60 cycles -> btn_press[0] at accept edge, at +20, then +26, +32, +38, +44, +50 while held; no repeat pulses without the macro.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning stage.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESS_CNT   = 2'b01,
    HELD        = 2'b10,
    RELEASE_CNT = 2'b11
  } btn_state_e;

  // 10 ms, 500 ms and 100 ms at the 100 MHz board clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned REPEAT_DELAY_DEF    = 50_000_000;
  localparam int unsigned REPEAT_PERIOD_DEF   = 10_000_000;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_C = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter and press/release FSM.
// Auto-repeat of the press pulse while held is added when BTN_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BTN_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d, press_pulse;
  logic             release_q, release_d;

  assign sync = sync_q[1];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d   = state_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_CNT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_CNT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RELEASE_CNT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_CNT: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = ($clog2(REP_MAX) > 0) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_fire;

  // Any cycle not spent steadily in HELD restarts the initial delay from zero.
  always_comb begin
    rep_d       = '0;
    rep_first_d = 1'b1;
    rep_fire    = 1'b0;
    if (state_q == HELD && sync) begin
      rep_first_d = rep_first_q;
      if (rep_q == (rep_first_q ? DELAY_LAST : PERIOD_LAST)) begin
        rep_fire    = 1'b1;
        rep_first_d = 1'b0;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign press_pulse = press_d | rep_fire;
`else
  assign press_pulse = press_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, keeping the 2-flop chain a real delay.
      sync_q    <= {sync_q[0], raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_pulse;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debouncer.sv
// Debounces the five Nexys4 push buttons {C,R,L,D,U} into clean levels and press/release pulses.
// Define BTN_REPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 2**24 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $error("btn_debouncer: parameter out of range");
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (btn_raw[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g])
    );
  end

endmodule
